// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and defaults for the reaction game player input path.
//   - pressState_e: press FSM states (idle, held, lockout)
//   - DefaultDebounceCycles / DefaultLockoutCycles: defaults for a 100 MHz clock
//   - PressCountW: width of the accepted-press counter
//   - counterWidth(): bit width needed to hold the values 0 .. n-1
package reaction_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHeld    = 2'd1,
        StLockout = 2'd2
    } pressState_e;

    localparam int unsigned DefaultDebounceCycles = 500000;    // 5 ms at 100 MHz
    localparam int unsigned DefaultLockoutCycles  = 50000000;  // 500 ms at 100 MHz
    localparam int unsigned PressCountW           = 8;

    // Width of a down/up counter that must hold 0 .. n-1 (at least one bit).
    function automatic int unsigned counterWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes the raw asynchronous button and debounces it.
//   clock      in   system clock
//   reset      in   synchronous, active-high
//   buttonRaw  in   asynchronous raw button level, high = pressed
//   deb        out  debounced level; flips only after DEBOUNCE_CYCLES consecutive
//                   cycles of the synchronized input disagreeing with it
module button_debouncer
    import reaction_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic clock,
    input  logic reset,
    input  logic buttonRaw,
    output logic deb
);

    localparam int unsigned DcW = counterWidth(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   s;
    logic [DcW-1:0]         dcQ, dcD;
    logic                   debQ, debD;

    assign s = syncQ[SYNC_STAGES-1];

    // Any cycle of agreement restarts the count, so short glitches are dropped.
    always_comb begin
        dcD  = dcQ;
        debD = debQ;
        if (s == debQ) begin
            dcD = '0;
        end else if (dcQ == DcW'(DEBOUNCE_CYCLES - 1)) begin
            debD = ~debQ;
            dcD  = '0;
        end else begin
            dcD = dcQ + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            syncQ <= '0;
            dcQ   <= '0;
            debQ  <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], buttonRaw};
            dcQ   <= dcD;
            debQ  <= debD;
        end
    end

    assign deb = debQ;

endmodule

// File: rtl/reaction_input.sv
// reaction_input: player-side front end of the reaction game. Turns the raw button into
// one playerReaction pulse per accepted press, with a lockout after release, and measures
// reaction latency from the cue rise to the accepted press.
//   clock            in   system clock
//   reset            in   synchronous, active-high
//   buttonRaw        in   asynchronous raw button, high = pressed
//   cueActive        in   high while a scored round window is open (clock domain)
//   playerReaction   out  one-cycle pulse per accepted press
//   earlyPress       out  one-cycle pulse with playerReaction when cueActive is low
//   reactionLatency  out  cycles from cue rise to accepted press, held until next capture
//   latencyValid     out  one-cycle pulse when reactionLatency updates
//   pressCount       out  accepted presses since reset (wraps)
// Build option: define REACTION_LATENCY_EN to implement the latency counter; otherwise
// reactionLatency and latencyValid are tied to zero.
module reaction_input
    import reaction_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned LOCKOUT_CYCLES  = DefaultLockoutCycles,
    parameter int unsigned LAT_W           = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   buttonRaw,
    input  logic                   cueActive,
    output logic                   playerReaction,
    output logic                   earlyPress,
    output logic [LAT_W-1:0]       reactionLatency,
    output logic                   latencyValid,
    output logic [PressCountW-1:0] pressCount
);

    localparam int unsigned LockW = counterWidth(LOCKOUT_CYCLES);

    logic                   deb;
    pressState_e            stateQ, stateD;
    logic [LockW-1:0]       lockQ, lockD;
    logic                   accept;
    logic                   pulseQ, earlyQ;
    logic [PressCountW-1:0] countQ;

    button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebouncer (
        .clock    (clock),
        .reset    (reset),
        .buttonRaw(buttonRaw),
        .deb      (deb)
    );

    // deb can only be high in StIdle when it has just risen: StIdle is entered only with
    // deb low (reset or end of lockout), so a high level here is a fresh press.
    always_comb begin
        stateD = stateQ;
        lockD  = lockQ;
        accept = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (deb) begin
                    accept = 1'b1;
                    stateD = StHeld;
                end
            end
            StHeld: begin
                if (!deb) begin
                    lockD  = LockW'(LOCKOUT_CYCLES - 1);
                    stateD = StLockout;
                end
            end
            StLockout: begin
                if (lockQ == '0) begin
                    // Still held at the end of lockout: wait for a release, no pulse.
                    stateD = deb ? StHeld : StIdle;
                end else begin
                    lockD = lockQ - 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ <= StIdle;
            lockQ  <= '0;
            pulseQ <= 1'b0;
            earlyQ <= 1'b0;
            countQ <= '0;
        end else begin
            stateQ <= stateD;
            lockQ  <= lockD;
            pulseQ <= accept;
            earlyQ <= accept & ~cueActive;
            if (accept) begin
                countQ <= countQ + 1'b1;
            end
        end
    end

    assign playerReaction = pulseQ;
    assign earlyPress     = earlyQ;
    assign pressCount     = countQ;

`ifdef REACTION_LATENCY_EN
    logic             cuePrevQ;
    logic             cueRise;
    logic             armedQ, armedD;
    logic             capture;
    logic             validQ;
    logic [LAT_W-1:0] cntQ, cntD, latQ, latD;

    assign cueRise = cueActive & ~cuePrevQ;

    // The counter reads 1 on the cycle after a cue rise, so a press decided in the cue
    // rise cycle itself captures 0 rather than the stale counter value.
    always_comb begin
        capture = accept & cueActive & (armedQ | cueRise);
        cntD    = cntQ;
        latD    = latQ;
        if (cueRise) begin
            cntD = LAT_W'(1);
        end else if (armedQ && (cntQ != '1)) begin
            cntD = cntQ + 1'b1;
        end
        if (capture) begin
            latD = cueRise ? '0 : cntQ;
        end
        armedD = (armedQ | cueRise) & ~capture;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cuePrevQ <= 1'b0;
            armedQ   <= 1'b0;
            cntQ     <= '0;
            latQ     <= '0;
            validQ   <= 1'b0;
        end else begin
            cuePrevQ <= cueActive;
            armedQ   <= armedD;
            cntQ     <= cntD;
            latQ     <= latD;
            validQ   <= capture;
        end
    end

    assign reactionLatency = latQ;
    assign latencyValid    = validQ;
`else
    assign reactionLatency = '0;
    assign latencyValid    = 1'b0;
`endif

endmodule

// File: tb/tb_reaction_input.sv
// tb_reaction_input: directed stimulus for reaction_input with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8. A timestamp-based model predicts every output each
// cycle; hand-computed literals pin the key timings. Cycle k is the interval after the k-th
// clock edge; inputs change mid-cycle (after the falling edge) and outputs are compared there.
module tb_reaction_input;

    localparam int unsigned Sync  = 2;
    localparam int unsigned Deb   = 4;
    localparam int unsigned Lock  = 8;
    localparam int unsigned LatW  = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            buttonRaw = 1'b0;
    logic            cueActive = 1'b0;
    logic            playerReaction, earlyPress, latencyValid;
    logic [LatW-1:0] reactionLatency;
    logic [7:0]      pressCount;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulseSeen = 0;
    bit started = 0;
    int base = 0;

    reaction_input #(
        .SYNC_STAGES    (Sync),
        .DEBOUNCE_CYCLES(Deb),
        .LOCKOUT_CYCLES (Lock),
        .LAT_W          (LatW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .buttonRaw      (buttonRaw),
        .cueActive      (cueActive),
        .playerReaction (playerReaction),
        .earlyPress     (earlyPress),
        .reactionLatency(reactionLatency),
        .latencyValid   (latencyValid),
        .pressCount     (pressCount)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw samples reach s after Sync edges; deb flips once the last Deb values of s all
    // disagree with it. A press is accepted when deb is high, no press is being held, and
    // the cycle is past the lockout that follows the last release.
    bit         rawQ[$];
    bit         sQ[$];
    bit         mDeb, mHeld, mCuePrev;
    int         mUnlock;
    bit         ePulse, eEarly, eValid;
    logic [7:0] eCount;
    logic [63:0] eLat;
`ifdef REACTION_LATENCY_EN
    bit         mArmed;
    int         mRise;
`endif

    task automatic modelReset();
        rawQ.delete();
        repeat (Sync) rawQ.push_back(1'b0);
        sQ.delete();
        mDeb = 0; mHeld = 0; mCuePrev = 0; mUnlock = 0;
        ePulse = 0; eEarly = 0; eValid = 0; eCount = '0; eLat = '0;
`ifdef REACTION_LATENCY_EN
        mArmed = 0; mRise = 0;
`endif
    endtask

    task automatic modelStep(input int c);
        bit accept, cueRise, s, allDiff;
        accept = 0;
        if (mHeld) begin
            if (!mDeb) begin
                mHeld   = 0;
                mUnlock = c + Lock + 1;
            end
        end else if (c >= mUnlock) begin
            if (mDeb) begin
                accept = 1;
                mHeld  = 1;
            end
        end else if (c == mUnlock - 1) begin
            if (mDeb) mHeld = 1;
        end
        cueRise = cueActive && !mCuePrev;
        ePulse  = accept;
        eEarly  = accept && !cueActive;
        eValid  = 0;
        if (accept) eCount = eCount + 8'd1;
`ifdef REACTION_LATENCY_EN
        if (cueRise) begin
            mArmed = 1;
            mRise  = c;
        end
        if (accept && cueActive && mArmed) begin
            longint d;
            d      = longint'(c - mRise);
            eLat   = (d > longint'((64'd1 << LatW) - 1)) ? ((64'd1 << LatW) - 1) : d;
            eValid = 1;
            mArmed = 0;
        end
`endif
        mCuePrev = cueActive;
        s = rawQ[0];
        sQ.push_back(s);
        if (sQ.size() > Deb) void'(sQ.pop_front());
        allDiff = (sQ.size() == Deb);
        foreach (sQ[i]) if (sQ[i] == mDeb) allDiff = 0;
        if (allDiff) begin
            mDeb = !mDeb;
            sQ.delete();
        end
        rawQ.push_back(buttonRaw);
        void'(rawQ.pop_front());
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clock);
            if (reset) modelReset();
            else modelStep(cyc);
            cyc++;
            started = 1;
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                chk("playerReaction", {63'd0, playerReaction}, {63'd0, ePulse});
                chk("earlyPress", {63'd0, earlyPress}, {63'd0, eEarly});
                chk("latencyValid", {63'd0, latencyValid}, {63'd0, eValid});
                chk("reactionLatency", 64'(reactionLatency), eLat);
                chk("pressCount", 64'(pressCount), 64'(eCount));
                if (playerReaction === 1'b1) pulseSeen++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic stepTo(input int rel);
        while (cyc - base < rel) step();
    endtask

    task automatic resetSeq();
        reset = 1; buttonRaw = 0; cueActive = 0;
        step(); step();
        reset = 0;
        base = cyc;
    endtask

    int p0;

    initial begin
        step(); step(); step();
        chk("reset playerReaction", {63'd0, playerReaction}, 64'd0);
        chk("reset pressCount", 64'(pressCount), 64'd0);
        chk("reset earlyPress", {63'd0, earlyPress}, 64'd0);
        chk("reset latencyValid", {63'd0, latencyValid}, 64'd0);
        chk("reset reactionLatency", 64'(reactionLatency), 64'd0);

        // Clean press from cycle 0: pulse only in cycle 7.
        reset = 0; base = cyc; p0 = pulseSeen;
        buttonRaw = 1;
        stepTo(6);
        chk("clean no pulse at 6", 64'(pulseSeen - p0), 64'd0);
        stepTo(7);
        chk("clean pulse at 7", {63'd0, playerReaction}, 64'd1);
        chk("clean earlyPress", {63'd0, earlyPress}, 64'd1);
        chk("clean pressCount", 64'(pressCount), 64'd1);
        stepTo(10); buttonRaw = 0;
        stepTo(40);
        chk("clean single pulse", 64'(pulseSeen - p0), 64'd1);

        // 3-cycle glitch is rejected.
        p0 = pulseSeen;
        buttonRaw = 1; stepTo(43); buttonRaw = 0;
        stepTo(60);
        chk("bounce no pulse", 64'(pulseSeen - p0), 64'd0);
        chk("bounce pressCount", 64'(pressCount), 64'd1);

        // Press, release, re-press inside lockout: lockout ends with deb high -> no pulse.
        base = cyc; p0 = pulseSeen;
        buttonRaw = 1; stepTo(10); buttonRaw = 0;
        stepTo(17); buttonRaw = 1; stepTo(40); buttonRaw = 0;
        stepTo(70);
        chk("lockout single pulse", 64'(pulseSeen - p0), 64'd1);
        chk("lockout pressCount", 64'(pressCount), 64'd2);

        // Cue high from cycle 9, press accepted (pulse) in cycle 30: latency 20.
        resetSeq();
        stepTo(9); cueActive = 1;
        stepTo(23); buttonRaw = 1;
        stepTo(30);
        chk("latency pulse at 30", {63'd0, playerReaction}, 64'd1);
        chk("latency earlyPress", {63'd0, earlyPress}, 64'd0);
`ifdef REACTION_LATENCY_EN
        chk("latency valid", {63'd0, latencyValid}, 64'd1);
        chk("latency value", 64'(reactionLatency), 64'd20);
`else
        chk("latency valid off", {63'd0, latencyValid}, 64'd0);
        chk("latency value off", 64'(reactionLatency), 64'd0);
`endif
        stepTo(35); buttonRaw = 0; cueActive = 0;
        stepTo(60);

        // Cue rises in the same cycle the press is decided: latency 0.
        base = cyc;
        buttonRaw = 1;
        stepTo(6); cueActive = 1;
        stepTo(7);
        chk("same-cycle pulse", {63'd0, playerReaction}, 64'd1);
        chk("same-cycle earlyPress", {63'd0, earlyPress}, 64'd0);
`ifdef REACTION_LATENCY_EN
        chk("same-cycle valid", {63'd0, latencyValid}, 64'd1);
`else
        chk("same-cycle valid off", {63'd0, latencyValid}, 64'd0);
`endif
        chk("same-cycle latency", 64'(reactionLatency), 64'd0);
        stepTo(10); buttonRaw = 0; cueActive = 0;
        stepTo(40);

        // Held 100 cycles with a reset at cycle 50: one pulse before, one at 58 after.
        resetSeq(); p0 = pulseSeen;
        buttonRaw = 1;
        stepTo(50);
        chk("held one pulse", 64'(pulseSeen - p0), 64'd1);
        reset = 1; stepTo(51); reset = 0;
        stepTo(57);
        chk("held no early repulse", 64'(pulseSeen - p0), 64'd1);
        stepTo(58);
        chk("held repulse at 58", {63'd0, playerReaction}, 64'd1);
        chk("held pressCount", 64'(pressCount), 64'd1);
        stepTo(100);
        chk("held total pulses", 64'(pulseSeen - p0), 64'd2);
        buttonRaw = 0;
        stepTo(130);

        // 256 accepted presses wrap the count to 0.
        resetSeq(); p0 = pulseSeen;
        for (int i = 0; i < 256; i++) begin
            buttonRaw = 1;
            repeat (8) step();
            buttonRaw = 0;
            repeat (20) step();
        end
        chk("wrap pulses", 64'(pulseSeen - p0), 64'd256);
        chk("wrap pressCount", 64'(pressCount), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
